// File: rtl/adder_pipe_pkg.sv
// adder_pipe_pkg: shared constants and helpers for the pipelined add/subtract unit.
package adder_pipe_pkg;

  // Operation mode encoding on the 'sub' input.
  localparam logic ADD_MODE = 1'b0;
  localparam logic SUB_MODE = 1'b1;

  // Bits handled by each pipeline slice.
  function automatic int calc_chunk(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal parameter combination: at least two bits, slices of equal size.
  function automatic logic params_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
  endfunction

  // Single-bit full-adder sum.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // Single-bit full-adder carry.
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (c & (x ^ y));
  endfunction

endpackage

// File: rtl/adder_pipe_slice.sv
// adder_slice: combinational CHUNK-bit ripple-carry chain of full-adder cells.
module adder_slice
  import adder_pipe_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  // Ripple the carry bit by bit from the LSB upwards.
  always_comb begin
    logic carry;
    carry = cin;
    sum   = {CHUNK{1'b0}};
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = fa_sum(a[i], b[i], carry);
      carry  = fa_carry(a[i], b[i], carry);
    end
    cout = carry;
  end

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: WIDTH-bit add/subtract split into STAGES registered ripple slices,
// with valid/ready handshaking, carry/borrow out and signed overflow.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = calc_chunk(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("adder_pipe: WIDTH must be >= 2 and an exact multiple of STAGES");
  end

  // Per-stage registers. Stage k holds the low (k+1)*CHUNK result bits, the
  // carry out of slice k and the operands still to be added by later slices.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  sum_q   [STAGES];
  logic [WIDTH-1:0]  sum_d   [STAGES];
  logic [WIDTH-1:0]  a_q     [STAGES];
  logic [WIDTH-1:0]  a_d     [STAGES];
  logic [WIDTH-1:0]  bp_q    [STAGES];
  logic [WIDTH-1:0]  bp_d    [STAGES];
  logic              carry_q [STAGES];
  logic              carry_d [STAGES];
  logic              sub_q   [STAGES];
  logic              sub_d   [STAGES];
  logic              amsb_q  [STAGES];
  logic              amsb_d  [STAGES];
  logic              bmsb_q  [STAGES];
  logic              bmsb_d  [STAGES];
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  // What each slice consumes: ports for slice 0, previous stage otherwise.
  logic [STAGES-1:0] src_valid;
  logic [WIDTH-1:0]  src_a    [STAGES];
  logic [WIDTH-1:0]  src_bp   [STAGES];
  logic [WIDTH-1:0]  src_sum  [STAGES];
  logic              src_cin  [STAGES];
  logic              src_sub  [STAGES];
  logic              src_amsb [STAGES];
  logic              src_bmsb [STAGES];

  logic [CHUNK-1:0]  sl_sum   [STAGES];
  logic              sl_cout  [STAGES];

  logic              stall;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;

  // Stall detection, subtract-mode operand inversion and slice input routing.
  always_comb begin
    stall   = valid_q[LAST] && !out_ready;
    b_eff   = (sub == SUB_MODE) ? ~b : b;
    cin_eff = (sub == SUB_MODE) ? ~cin : cin;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        src_valid[k] = in_valid;
        src_a[k]     = a;
        src_bp[k]    = b_eff;
        src_sum[k]   = {WIDTH{1'b0}};
        src_cin[k]   = cin_eff;
        src_sub[k]   = sub;
        src_amsb[k]  = a[WIDTH-1];
        src_bmsb[k]  = b_eff[WIDTH-1];
      end else begin
        src_valid[k] = valid_q[k-1];
        src_a[k]     = a_q[k-1];
        src_bp[k]    = bp_q[k-1];
        src_sum[k]   = sum_q[k-1];
        src_cin[k]   = carry_q[k-1];
        src_sub[k]   = sub_q[k-1];
        src_amsb[k]  = amsb_q[k-1];
        src_bmsb[k]  = bmsb_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(
      .CHUNK(CHUNK)
    ) u_slice (
      .a   (src_a[k][k*CHUNK +: CHUNK]),
      .b   (src_bp[k][k*CHUNK +: CHUNK]),
      .cin (src_cin[k]),
      .sum (sl_sum[k]),
      .cout(sl_cout[k])
    );
  end

  // Next state: hold everything while stalled, otherwise advance all stages.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (stall) begin
        valid_d[k] = valid_q[k];
        sum_d[k]   = sum_q[k];
        a_d[k]     = a_q[k];
        bp_d[k]    = bp_q[k];
        carry_d[k] = carry_q[k];
        sub_d[k]   = sub_q[k];
        amsb_d[k]  = amsb_q[k];
        bmsb_d[k]  = bmsb_q[k];
      end else begin
        valid_d[k] = src_valid[k];
        sum_d[k]   = src_sum[k];
        sum_d[k][k*CHUNK +: CHUNK] = sl_sum[k];
        a_d[k]     = src_a[k];
        bp_d[k]    = src_bp[k];
        carry_d[k] = sl_cout[k];
        sub_d[k]   = src_sub[k];
        amsb_d[k]  = src_amsb[k];
        bmsb_d[k]  = src_bmsb[k];
      end
    end
    if (stall) begin
      cout_d = cout_q;
      ovf_d  = ovf_q;
    end else begin
      // Raw carry becomes a borrow flag in subtract mode.
      cout_d = sl_cout[LAST] ^ (src_sub[LAST] == SUB_MODE);
      ovf_d  = (src_amsb[LAST] == src_bmsb[LAST]) &&
               (sl_sum[LAST][CHUNK-1] != src_amsb[LAST]);
    end
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= {STAGES{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k]   <= {WIDTH{1'b0}};
        a_q[k]     <= {WIDTH{1'b0}};
        bp_q[k]    <= {WIDTH{1'b0}};
        carry_q[k] <= 1'b0;
        sub_q[k]   <= 1'b0;
        amsb_q[k]  <= 1'b0;
        bmsb_q[k]  <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k]   <= sum_d[k];
        a_q[k]     <= a_d[k];
        bp_q[k]    <= bp_d[k];
        carry_q[k] <= carry_d[k];
        sub_q[k]   <= sub_d[k];
        amsb_q[k]  <= amsb_d[k];
        bmsb_q[k]  <= bmsb_d[k];
      end
    end
  end

  assign in_ready  = !stall;
  assign out_valid = valid_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
